// File: rtl/dfd_vlt_packer.sv
// Trace packet packer: compacts enabled bytes behind a small header into a byte FIFO
// and drains it as fixed-width beats. Optional stats counters via DFD_VLT_PACKER_STATS_EN.
module dfd_vlt_packer #(
  parameter int NUM_BYTES    = 16,
  parameter int OUT_BYTES    = 8,
  parameter int BUF_BYTES    = 64,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                                         clock,
  input  logic                                         reset_n,
  input  logic [NUM_BYTES*8-1:0]                       data_in,
  input  logic [NUM_BYTES-1:0]                         byte_en_in,
  input  logic [NUM_BYTES*($clog2(NUM_BYTES)+1)-1:0]   be_sum_in,
  input  logic [1:0]                                   trace_info_in,
  output logic [OUT_BYTES*8-1:0]                       out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         packet_lost,
  output logic                                         resync_req,
  output logic [$clog2(BUF_BYTES):0]                   fill_level,
  output logic [15:0]                                  drop_count,
  output logic [15:0]                                  pkt_count
);

  localparam int SW      = $clog2(NUM_BYTES) + 1;
  localparam int MB      = NUM_BYTES / 8;
  localparam int HDR     = 2 + MB;
  localparam int PKT_MAX = HDR + NUM_BYTES;
  localparam int AW      = $clog2(BUF_BYTES);
  localparam int FW      = AW + 1;
  localparam int IW      = $clog2(FLUSH_CYCLES + 1);

  logic [7:0]    r_mem [BUF_BYTES];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [FW-1:0] r_fill;
  logic [IW-1:0] r_idle;
  logic          r_flush;
  logic          r_lost;
  logic          r_resync;

  logic [SW-1:0] w_count;
  logic [7:0]    w_pkt [PKT_MAX];
  logic          w_present;
  logic [FW-1:0] w_len;
  logic [FW-1:0] w_free;
  logic          w_accept;
  logic          w_drop;
  logic          w_pop;
  logic [FW-1:0] w_popCount;
  logic [FW-1:0] w_fillNext;
  logic          w_idleRange;
  logic          w_idleHit;

  // Packet image: header, enable mask, then data bytes placed by the upstream prefix sums.
  always_comb begin
    w_count = be_sum_in[(NUM_BYTES-1)*SW +: SW];
    for (int j = 0; j < PKT_MAX; j++) begin
      w_pkt[j] = 8'h00;
    end
    w_pkt[0] = 8'(w_count);
    w_pkt[1] = {6'b0, trace_info_in};
    for (int m = 0; m < MB; m++) begin
      w_pkt[2+m] = byte_en_in[8*m +: 8];
    end
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_en_in[i] && (be_sum_in[i*SW +: SW] != '0) &&
          (int'(be_sum_in[i*SW +: SW]) <= NUM_BYTES)) begin
        w_pkt[HDR + int'(be_sum_in[i*SW +: SW]) - 1] = data_in[8*i +: 8];
      end
    end
  end

  assign w_present   = (byte_en_in != '0) || (trace_info_in != 2'b00);
  assign w_len       = FW'(HDR) + FW'(w_count);
  assign w_free      = FW'(BUF_BYTES) - r_fill;
  assign w_accept    = w_present && (w_free >= w_len);
  assign w_drop      = w_present && !w_accept;
  assign w_popCount  = (r_fill >= FW'(OUT_BYTES)) ? FW'(OUT_BYTES) : r_fill;
  assign w_pop       = out_valid && out_ready;
  assign w_fillNext  = r_fill + (w_accept ? w_len : '0) - (w_pop ? w_popCount : '0);
  assign w_idleRange = (r_fill != '0) && (r_fill < FW'(OUT_BYTES));
  assign w_idleHit   = !w_accept && w_idleRange && (r_idle >= IW'(FLUSH_CYCLES - 1));

  // Beat view: bytes past the fill level read as zero pads; nothing shown while in reset.
  always_comb begin
    out_data  = '0;
    out_valid = reset_n && ((r_fill >= FW'(OUT_BYTES)) || (r_flush && (r_fill != '0)));
    for (int k = 0; k < OUT_BYTES; k++) begin
      if (reset_n && (FW'(k) < r_fill)) begin
        out_data[8*k +: 8] = r_mem[r_rptr + AW'(k)];
      end
    end
  end

  // Storage is not reset; pointers and fill level define what is valid.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int j = 0; j < PKT_MAX; j++) begin
        if (j < int'(w_len)) begin
          r_mem[r_wptr + AW'(j)] <= w_pkt[j];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_fill   <= '0;
      r_idle   <= '0;
      r_flush  <= 1'b0;
      r_lost   <= 1'b0;
      r_resync <= 1'b0;
    end else begin
      r_fill <= w_fillNext;
      r_lost <= w_drop;
      if (w_accept) begin
        r_wptr <= r_wptr + AW'(w_len);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(w_popCount);
      end
      if (w_accept) begin
        r_idle <= '0;
      end else if (w_idleRange) begin
        if (r_idle != IW'(FLUSH_CYCLES)) begin
          r_idle <= r_idle + IW'(1);
        end
      end else begin
        r_idle <= '0;
      end
      if (w_fillNext == '0) begin
        r_flush <= 1'b0;
      end else if (w_idleHit || (w_accept && (trace_info_in == 2'b10))) begin
        r_flush <= 1'b1;
      end
      // A drop outranks the clearing effect of an accepted full packet.
      if (w_drop) begin
        r_resync <= 1'b1;
      end else if (w_accept && (w_count == SW'(NUM_BYTES))) begin
        r_resync <= 1'b0;
      end
    end
  end

  assign packet_lost = r_lost;
  assign resync_req  = r_resync;
  assign fill_level  = r_fill;

`ifdef DFD_VLT_PACKER_STATS_EN
  logic [15:0] r_dropCount;
  logic [15:0] r_pktCount;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_dropCount <= '0;
      r_pktCount  <= '0;
    end else begin
      if (w_drop && (r_dropCount != 16'hFFFF)) begin
        r_dropCount <= r_dropCount + 16'd1;
      end
      if (w_accept && (r_pktCount != 16'hFFFF)) begin
        r_pktCount <= r_pktCount + 16'd1;
      end
    end
  end

  assign drop_count = r_dropCount;
  assign pkt_count  = r_pktCount;
`else
  assign drop_count = '0;
  assign pkt_count  = '0;
`endif

endmodule

// File: tb/tb_dfd_vlt_packer.sv
// Self-checking bench for dfd_vlt_packer: byte-stream scoreboard plus per-cycle
// checks of fill level, drop pulse and resync flag against a reference model.
module tb_dfd_vlt_packer;

  localparam int NB = 16;
  localparam int OB = 8;
  localparam int BB = 64;
  localparam int SW = 5;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NB*8-1:0] data_in;
  logic [NB-1:0]   byte_en_in;
  logic [NB*SW-1:0] be_sum_in;
  logic [1:0]      trace_info_in;
  logic [OB*8-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            packet_lost;
  logic            resync_req;
  logic [6:0]      fill_level;
  logic [15:0]     drop_count;
  logic [15:0]     pkt_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ[$];
  logic       expLost = 1'b0;
  logic       expResync = 1'b0;
  int         modelDrops = 0;
  int         modelPkts = 0;
  logic [NB*8-1:0] fullData;
  logic [NB*8-1:0] sparseData;

  dfd_vlt_packer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .byte_en_in    (byte_en_in),
    .be_sum_in     (be_sum_in),
    .trace_info_in (trace_info_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .packet_lost   (packet_lost),
    .resync_req    (resync_req),
    .fill_level    (fill_level),
    .drop_count    (drop_count),
    .pkt_count     (pkt_count)
  );

  always #5 clock = ~clock;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check state, model the coming rising edge.
  task automatic applyStimulus(input logic [NB-1:0] en, input logic [NB*8-1:0] data,
                               input logic [1:0] ti, input logic rdy);
    int          sum;
    int          prefill;
    int          n;
    logic [63:0] beat;
    @(negedge clock);
    byte_en_in    = en;
    data_in       = data;
    trace_info_in = ti;
    out_ready     = rdy;
    sum = 0;
    for (int i = 0; i < NB; i++) begin
      sum += int'(en[i]);
      be_sum_in[i*SW +: SW] = 5'(sum);
    end
    #1;
    prefill = expQ.size();
    checkOutput("fill", 64'(fill_level), 64'(prefill));
    checkOutput("lost", 64'(packet_lost), 64'(expLost));
    checkOutput("resync", 64'(resync_req), 64'(expResync));
    if (prefill >= OB) checkOutput("validFull", 64'(out_valid), 64'd1);
    if (prefill == 0) checkOutput("validEmpty", 64'(out_valid), 64'd0);
    if (out_valid && out_ready) begin
      beat = '0;
      n = (prefill < OB) ? prefill : OB;
      for (int k = 0; k < n; k++) beat[8*k +: 8] = expQ[k];
      for (int k = 0; k < n; k++) void'(expQ.pop_front());
      checkOutput("beat", out_data, beat);
    end
    expLost = 1'b0;
    if ((en != '0) || (ti != 2'b00)) begin
      if (BB - prefill >= 2 + NB/8 + sum) begin
        expQ.push_back(8'(sum));
        expQ.push_back({6'b0, ti});
        expQ.push_back(en[7:0]);
        expQ.push_back(en[15:8]);
        for (int i = 0; i < NB; i++) begin
          if (en[i]) expQ.push_back(data[8*i +: 8]);
        end
        if (modelPkts < 65535) modelPkts++;
        if (sum == NB) expResync = 1'b0;
      end else begin
        expLost   = 1'b1;
        expResync = 1'b1;
        if (modelDrops < 65535) modelDrops++;
      end
    end
  endtask

  task automatic drainAll(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() > 0) && (n < maxCycles)) begin
      applyStimulus('0, '0, 2'b00, 1'b1);
      n++;
    end
    applyStimulus('0, '0, 2'b00, 1'b1);
    checkOutput("drained", 64'(fill_level), 64'd0);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset_n       = 1'b0;
    byte_en_in    = '0;
    data_in       = '0;
    be_sum_in     = '0;
    trace_info_in = 2'b00;
    out_ready     = 1'b1;
    #1;
    checkOutput("rstCycleValid", 64'(out_valid), 64'd0);
    expQ.delete();
    expLost   = 1'b0;
    expResync = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("rstFill", 64'(fill_level), 64'd0);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstResync", 64'(resync_req), 64'd0);
    checkOutput("rstData", out_data, 64'd0);
  endtask

  initial begin
    logic [NB-1:0]   en;
    logic [NB*8-1:0] rnd;
    int a;
    int b;
    for (int i = 0; i < NB; i++) fullData[8*i +: 8] = 8'(i);
    sparseData        = '0;
    sparseData[7:0]   = 8'hAA;
    sparseData[23:16] = 8'hCC;

    reset_n       = 1'b0;
    byte_en_in    = '0;
    data_in       = '0;
    be_sum_in     = '0;
    trace_info_in = 2'b00;
    out_ready     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("initValid", 64'(out_valid), 64'd0);
    checkOutput("initData", out_data, 64'd0);
    checkOutput("initLost", 64'(packet_lost), 64'd0);
    checkOutput("initResync", 64'(resync_req), 64'd0);
    checkOutput("initFill", 64'(fill_level), 64'd0);
    checkOutput("initDropCount", 64'(drop_count), 64'd0);
    checkOutput("initPktCount", 64'(pkt_count), 64'd0);
    reset_n = 1'b1;

    $display("[TB] sparse packet with idle flush");
    applyStimulus(16'h0005, sparseData, 2'b00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      applyStimulus('0, '0, 2'b00, 1'b1);
      checkOutput("noEarlyFlush", 64'(out_valid), 64'd0);
    end
    drainAll(20);

    $display("[TB] full packet with start");
    applyStimulus(16'hFFFF, fullData, 2'b01, 1'b1);
    drainAll(40);

    $display("[TB] stop packet flushes at once");
    applyStimulus(16'h0001, {120'h0, 8'h5A}, 2'b10, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus('0, '0, 2'b00, 1'b1);
    checkOutput("stopFlush", 64'(fill_level), 64'd0);

    $display("[TB] overflow and resync");
    for (int p = 0; p < 4; p++) applyStimulus(16'hFFFF, fullData, 2'b00, 1'b0);
    applyStimulus('0, '0, 2'b00, 1'b1);
    for (int c = 0; (c < 10) && (expQ.size() > 44); c++) applyStimulus('0, '0, 2'b00, 1'b1);
    applyStimulus(16'hFFFF, fullData, 2'b00, 1'b1);
    applyStimulus('0, '0, 2'b00, 1'b1);
    checkOutput("resyncCleared", 64'(resync_req), 64'd0);
    drainAll(40);

    $display("[TB] wrap-around stream");
    for (int i = 0; i < 60; i++) begin
      if ((i % 3) != 2) begin
        a   = $urandom_range(0, 15);
        b   = (a + 1 + $urandom_range(0, 14)) % 16;
        en  = (16'h1 << a) | (16'h1 << b);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(en, rnd, 2'b00, 1'(i % 2));
      end else begin
        applyStimulus('0, '0, 2'b00, 1'(i % 2));
      end
    end
    drainAll(60);

    $display("[TB] reset mid-stream");
    applyStimulus(16'hFFFF, fullData, 2'b00, 1'b0);
    applyStimulus(16'hFFFF, fullData, 2'b00, 1'b0);
    applyStimulus(16'h0001, {120'h0, 8'h11}, 2'b00, 1'b0);
    applyStimulus('0, '0, 2'b00, 1'b0);
    applyReset();
    applyStimulus(16'h00FF, fullData, 2'b10, 1'b1);
    drainAll(20);

`ifdef DFD_VLT_PACKER_STATS_EN
    checkOutput("dropCount", 64'(drop_count), 64'(modelDrops));
    checkOutput("pktCount", 64'(pkt_count), 64'(modelPkts));
`else
    checkOutput("dropCount", 64'(drop_count), 64'd0);
    checkOutput("pktCount", 64'(pkt_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
